bit_stuffer: RTL and testbench

USB bit-stuffing stage placed directly downstream of the CRC appender in the transmit serial path. It consumes the CRC stage's `outb`/`sending` bitstream and forwards it unchanged, except that it inserts a `0` after every run of `MAX_ONES` consecutive `1`s, per USB bit-stuffing. While it inserts that `0` it stalls the CRC stage through `pause_in`, which drives the CRC stage's `pause_out`. Downstream stalls are passed straight through to the CRC stage.

---
 rtl/usb_pkg.sv | 8 +
 rtl/counter.sv | 27 ++
 rtl/bit_stuffer.sv | 112 +++++++++++
 tb/tb_bit_stuffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB transmit-path types and constants.
package usb_pkg;

    typedef enum logic [1:0] {STF_IDLE, STF_PASS, STF_STUFF} stuff_state_t;

    localparam int unsigned USB_MAX_ONES = 6;

endpackage

// File: rtl/counter.sv
// Generic up/down counter with synchronous clear and async active-low reset.
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             clr_cnt,
    input  logic             inc_cnt,
    input  logic             up,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (inc_cnt) begin
            r_cnt <= up ? r_cnt + 1'b1 : r_cnt - 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/bit_stuffer.sv
// USB bit stuffer: inserts a 0 after every MAX_ONES consecutive 1s and
// stalls the upstream CRC stage for the inserted bit.
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int unsigned MAX_ONES    = USB_MAX_ONES,
    parameter int unsigned STUFF_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_L,
    input  logic                   inb,
    input  logic                   recving,
    input  logic                   pause_out,
    output logic                   pause_in,
    output logic                   outb,
    output logic                   sending,
    output logic [STUFF_CNT_W-1:0] stuffed_cnt
);

    localparam int unsigned          ONES_W    = $clog2(MAX_ONES + 1);
    localparam logic [ONES_W-1:0]    ONES_LAST = ONES_W'(MAX_ONES - 1);

    stuff_state_t           r_state;
    stuff_state_t           w_next;
    logic [ONES_W-1:0]      w_ones;
    logic                   w_clr_ones;
    logic                   w_inc_ones;
    logic                   w_start;
    logic                   w_stuff_done;
    logic                   w_active;
    logic [STUFF_CNT_W-1:0] r_stuffed;

    counter #(
        .WIDTH (ONES_W)
    ) u_ones (
        .clk     (clk),
        .rst_L   (rst_L),
        .clr_cnt (w_clr_ones),
        .inc_cnt (w_inc_ones),
        .up      (1'b1),
        .cnt     (w_ones)
    );

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= STF_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // IDLE forwards the first bit combinationally; gating with rst_L keeps
    // the outputs at 0 while reset is held even if recving is already high.
    assign w_active = (r_state == STF_PASS) || ((r_state == STF_IDLE) && recving && rst_L);

    always_comb begin
        w_next       = r_state;
        w_clr_ones   = 1'b0;
        w_inc_ones   = 1'b0;
        w_start      = 1'b0;
        w_stuff_done = 1'b0;
        outb         = 1'b0;
        sending      = 1'b0;
        pause_in     = 1'b0;
        unique case (r_state)
            STF_IDLE, STF_PASS: begin
                if (w_active) begin
                    w_start  = (r_state == STF_IDLE);
                    sending  = 1'b1;
                    outb     = inb;
                    pause_in = pause_out;
                    w_next   = STF_PASS;
                    if (!recving) begin
                        w_next     = STF_IDLE;
                        w_clr_ones = 1'b1;
                    end else if (!pause_out) begin
                        if (inb && (w_ones == ONES_LAST)) begin
                            w_clr_ones = 1'b1;
                            w_next     = STF_STUFF;
                        end else if (inb) begin
                            w_inc_ones = 1'b1;
                        end else begin
                            w_clr_ones = 1'b1;
                        end
                    end
                end
            end
            STF_STUFF: begin
                sending  = 1'b1;
                pause_in = 1'b1;
                if (!pause_out) begin
                    w_stuff_done = 1'b1;
                    w_next       = recving ? STF_PASS : STF_IDLE;
                end
            end
            default: w_next = STF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_stuffed <= '0;
        end else if (w_start) begin
            r_stuffed <= '0;
        end else if (w_stuff_done && (r_stuffed != '1)) begin
            r_stuffed <= r_stuffed + 1'b1;
        end
    end

    assign stuffed_cnt = r_stuffed;

endmodule

// File: tb/tb_bit_stuffer.sv
// Bench for bit_stuffer: directed scenarios plus randomized packets with
// random downstream stalls, checked against a queue-based stuffing model.
module tb_bit_stuffer;
    import usb_pkg::*;

    localparam int unsigned MAXO = 6;
    localparam int unsigned CW   = 8;

    typedef logic lq_t[$];

    logic          clk = 1'b0;
    logic          rst_L;
    logic          inb;
    logic          recving;
    logic          pause_out;
    logic          pause_in;
    logic          outb;
    logic          sending;
    logic [CW-1:0] stuffed_cnt;

    int n_vec = 0;
    int n_err = 0;

    lq_t pkt, got, exp_q;
    lq_t tr_outb, tr_send, tr_pin;
    int  tr_ones[$];
    lq_t pq;
    bit  rnd_pause;
    int  stalls;
    int  exp_n;

    always #5 clk = ~clk;

    bit_stuffer #(
        .MAX_ONES    (MAXO),
        .STUFF_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .inb         (inb),
        .recving     (recving),
        .pause_out   (pause_out),
        .pause_in    (pause_in),
        .outb        (outb),
        .sending     (sending),
        .stuffed_cnt (stuffed_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input lq_t q, input int unsigned first, input int unsigned n);
        logic [63:0] v = '0;
        for (int unsigned i = first; i < first + n; i++)
            v = {v[62:0], (i < q.size()) ? q[i] : 1'bx};
        return v;
    endfunction

    // Reference: every MAXO consecutive 1s are followed by an inserted 0.
    task automatic model(input lq_t in, output lq_t out, output int n);
        int run = 0;
        out = {};
        n   = 0;
        foreach (in[i]) begin
            out.push_back(in[i]);
            run = in[i] ? run + 1 : 0;
            if (run == MAXO) begin
                out.push_back(1'b0);
                n++;
                run = 0;
            end
        end
    endtask

    // Upstream source + downstream sink for one packet in pkt; records a
    // per-cycle trace and the bit stream the sink accepted.
    task automatic drive();
        int  idx   = 0;
        int  cyc   = 0;
        int  limit = 200 + 4 * pkt.size();
        bit  done  = 0;
        got = {};  tr_outb = {};  tr_send = {};  tr_pin = {};  tr_ones = {};
        stalls = 0;
        while (!done) begin
            recving   = (idx < pkt.size());
            inb       = recving ? pkt[idx] : 1'($urandom);
            pause_out = (cyc < pq.size()) ? pq[cyc]
                      : (rnd_pause ? ($urandom_range(0, 3) == 0) : 1'b0);
            #4;
            tr_outb.push_back(outb);
            tr_send.push_back(sending);
            tr_pin.push_back(pause_in);
            tr_ones.push_back(int'(dut.w_ones));
            if (sending && !pause_out && (recving || pause_in)) got.push_back(outb);
            if (pause_in && !pause_out) stalls++;
            if (recving && !pause_in) idx++;
            if (!recving && !sending) done = 1;
            cyc++;
            if (cyc > limit) begin
                chk("drive_timeout", 64'(cyc), 64'(limit));
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        recving   = 1'b0;
        pause_out = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_L = 1'b0; inb = 1'b0; recving = 1'b0; pause_out = 1'b0; rnd_pause = 0;
        #12;
        chk("reset_outputs", {61'd0, sending, pause_in, outb}, 64'd0);
        chk("reset_stuffed", 64'(stuffed_cnt), 64'd0);
        @(posedge clk); #1 rst_L = 1'b1;
        @(posedge clk); #1;

        // Seven 1s: 1,1,1,1,1,1,0,1 with one stall on the 7th cycle.
        pkt = {1, 1, 1, 1, 1, 1, 1};  pq = {};
        drive();
        chk("seven_outb", pack(tr_outb, 0, 8), 64'b11111101);
        chk("seven_pause_in", pack(tr_pin, 0, 8), 64'b00000010);
        chk("seven_stuffed", 64'(stuffed_cnt), 64'd1);

        // Interrupted runs: no stuffing.
        pkt = {1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        drive();
        chk("norun_stream", pack(got, 0, 11), 64'b11111011111);
        chk("norun_len", 64'(got.size()), 64'd11);
        chk("norun_stalls", 64'(stalls), 64'd0);
        chk("norun_stuffed", 64'(stuffed_cnt), 64'd0);

        // Six 1s then recving drops: trailing stuffed 0 is still sent.
        pkt = {1, 1, 1, 1, 1, 1};
        drive();
        chk("tail_stuff", {62'd0, tr_send[6], tr_outb[6]}, 64'b10);
        chk("tail_idle_send", 64'(tr_send[7]), 64'd0);
        chk("tail_cycles", 64'(tr_send.size()), 64'd8);
        chk("tail_state", 64'(dut.r_state), 64'(STF_IDLE));

        // Downstream stall for 2 cycles after the 3rd 1.
        pkt = {1, 1, 1, 1, 1, 1};
        pq  = {0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        drive();
        chk("pause_mirror", pack(tr_pin, 0, 9), 64'b000110001);
        chk("pause_ones_c3", 64'(tr_ones[3]), 64'd3);
        chk("pause_ones_c4", 64'(tr_ones[4]), 64'd3);
        chk("pause_stuff_at", {62'd0, tr_outb[7], tr_outb[8]}, 64'b10);
        chk("pause_stream", pack(got, 0, 7), 64'b1111110);
        pq = {};

        // Fourteen 1s: two stuffed bits.
        pkt = {};
        repeat (14) pkt.push_back(1'b1);
        drive();
        chk("fourteen_stream", pack(got, 0, 16), 64'b1111110111111011);
        chk("fourteen_len", 64'(got.size()), 64'd16);
        chk("fourteen_stuffed", 64'(stuffed_cnt), 64'd2);

        // Asynchronous reset in the middle of STUFF.
        for (int i = 0; i < 6; i++) begin
            recving = 1'b1; inb = 1'b1; pause_out = 1'b0;
            @(posedge clk); #1;
        end
        #1;
        chk("pre_reset_stuff", {61'd0, sending, pause_in, outb}, 64'b110);
        rst_L = 1'b0;
        #1;
        chk("async_reset_out", {61'd0, sending, pause_in, outb}, 64'd0);
        chk("async_reset_ones", 64'(dut.w_ones), 64'd0);
        recving = 1'b0;
        @(posedge clk); #1 rst_L = 1'b1;
        @(posedge clk); #1;
        pkt = {1, 1, 1, 1, 1, 1, 1};
        drive();
        chk("post_reset_outb", pack(tr_outb, 0, 8), 64'b11111101);
        chk("post_reset_stuffed", 64'(stuffed_cnt), 64'd1);

        // Long run of 1s: stuffed_cnt saturates at all-ones.
        pkt = {};
        repeat (MAXO * 260) pkt.push_back(1'b1);
        drive();
        chk("sat_stuffed", 64'(stuffed_cnt), 64'(2 ** CW - 1));
        chk("sat_len", 64'(got.size()), 64'(MAXO * 260 + 260));
        chk("sat_stalls", 64'(stalls), 64'd260);

        // Random packets with random downstream stalls.
        rnd_pause = 1;
        for (int p = 0; p < 40; p++) begin
            int unsigned len = $urandom_range(1, 40);
            pkt = {};
            for (int unsigned i = 0; i < len; i++) pkt.push_back($urandom_range(0, 3) != 0);
            model(pkt, exp_q, exp_n);
            drive();
            chk($sformatf("rand%0d_len", p), 64'(got.size()), 64'(exp_q.size()));
            chk($sformatf("rand%0d_stream", p), pack(got, 0, exp_q.size()), pack(exp_q, 0, exp_q.size()));
            chk($sformatf("rand%0d_stuffed", p), 64'(stuffed_cnt), 64'(exp_n));
            chk($sformatf("rand%0d_stalls", p), 64'(stalls), 64'(exp_n));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
